// File: rtl/nn_pins_pkg.sv
// Shared constants for the neuron-network core pin interface: target ids,
// uio bit positions and the host streamer FSM states.
package nn_pins_pkg;

    localparam logic [2:0] TGT_W          = 3'd0;
    localparam logic [2:0] TGT_BETA_SHIFT = 3'd1;
    localparam logic [2:0] TGT_MINUS_TETA = 3'd2;
    localparam logic [2:0] TGT_BN_FACTOR  = 3'd3;
    localparam logic [2:0] TGT_BN_ADDEND  = 3'd4;
    localparam logic [2:0] TGT_INPUTS     = 3'd5;

    localparam int UIO_PARAM_LSB      = 0;
    localparam int UIO_W_CE           = 2;
    localparam int UIO_BETA_SHIFT_CE  = 3;
    localparam int UIO_MINUS_TETA_CE  = 4;
    localparam int UIO_BN_FACTOR_CE   = 5;
    localparam int UIO_BN_ADDEND_CE   = 6;
    localparam int UIO_INPUTS_CE      = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_DISCARD
    } state_e;

endpackage

// File: rtl/nn_dibit_serializer.sv
// Splits a loaded byte into PARAM_BITS-wide symbols, LSB symbol first, one per
// cycle onto a registered output with a matching strobe; hold freezes it all.
module nn_dibit_serializer
    import nn_pins_pkg::*;
#(
    parameter int PARAM_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [7:0]            data_i,
    input  logic                  hold_i,
    output logic [PARAM_BITS-1:0] dibit_o,
    output logic                  strobe_o,
    output logic                  empty_o,
    output logic                  last_o
);

    localparam int NDIB = 8 / PARAM_BITS;
    localparam int CW   = $clog2(NDIB);

    logic [7:0]            sh_q, sh_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic [PARAM_BITS-1:0] dib_q, dib_d;
    logic                  stb_q, stb_d;

    // rem_q counts symbols still waiting in sh_q, not the one on the pins
    always_comb begin
        sh_d  = sh_q;
        rem_d = rem_q;
        dib_d = dib_q;
        stb_d = 1'b0;
        if (!hold_i) begin
            if (load_i) begin
                dib_d = data_i[PARAM_BITS-1:0];
                sh_d  = data_i >> PARAM_BITS;
                rem_d = CW'(NDIB - 1);
                stb_d = 1'b1;
            end else if (rem_q != '0) begin
                dib_d = sh_q[PARAM_BITS-1:0];
                sh_d  = sh_q >> PARAM_BITS;
                rem_d = rem_q - CW'(1);
                stb_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q  <= '0;
            rem_q <= '0;
            dib_q <= '0;
            stb_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            rem_q <= rem_d;
            dib_q <= dib_d;
            stb_q <= stb_d;
        end
    end

    assign dibit_o  = dib_q;
    assign strobe_o = stb_q;
    assign empty_o  = (rem_q == '0);
    assign last_o   = (rem_q == '0) && stb_q;

endmodule

// File: rtl/nn_param_streamer.sv
// Host-side framer: decodes header/length from a byte stream and serialises the
// payload onto the core's ui/uio pins with the matching FIFO clock enable.
module nn_param_streamer
    import nn_pins_pkg::*;
#(
    parameter int PARAM_BITS = 2,
    parameter int LEN_BITS   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       hold,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio,
    output logic       busy,
    output logic       frame_done,
    output logic       bad_target
);

    localparam logic [LEN_BITS-1:0] CNT_ONE = LEN_BITS'(1);

    state_e                state_q, state_d;
    logic [2:0]            tgt_q, tgt_d;
    logic                  discard_q, discard_d;
    logic [LEN_BITS-1:0]   cnt_q, cnt_d;
    logic [7:0]            ui_q, ui_d;
    logic                  ui_stb_q, ui_stb_d;
    logic                  done_q, done_d;
    logic                  bad_q, bad_d;

    logic                  ser_load;
    logic [PARAM_BITS-1:0] ser_dibit;
    logic                  ser_strobe, ser_empty, ser_last;
    logic                  accept, is_inputs;
    logic [5:0]            ce_vec;

    nn_dibit_serializer #(.PARAM_BITS(PARAM_BITS)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ser_load),
        .data_i  (s_data),
        .hold_i  (hold),
        .dibit_o (ser_dibit),
        .strobe_o(ser_strobe),
        .empty_o (ser_empty),
        .last_o  (ser_last)
    );

    assign is_inputs = (tgt_q == TGT_INPUTS);
    assign accept    = s_valid && s_ready;

    // Payload bytes stop being accepted once the count hits zero, so the next
    // header waits for IDLE even while the last byte is still on the pins.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DISCARD: s_ready = 1'b1;
            ST_PAYLOAD: s_ready = !hold && (cnt_q != '0) && (is_inputs || ser_empty);
            default:    s_ready = 1'b0;
        endcase
        if (reset) s_ready = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;
        ui_d      = ui_q;
        ui_stb_d  = 1'b0;
        done_d    = 1'b0;
        bad_d     = 1'b0;
        ser_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d     = s_data[7:5];
                    discard_d = (s_data[7:5] > TGT_INPUTS);
                    bad_d     = discard_d;
                    state_d   = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    cnt_d   = LEN_BITS'(s_data);
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    cnt_d = LEN_BITS'({s_data, cnt_q[7:0]});
                    if (cnt_d == '0) begin
                        done_d  = !discard_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = discard_q ? ST_DISCARD : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (is_inputs) begin
                        ui_d     = s_data;
                        ui_stb_d = 1'b1;
                    end else begin
                        ser_load = 1'b1;
                    end
                end
                // Final strobe is on the pins now; done lands with IDLE next cycle
                if (cnt_q == '0 && (is_inputs ? ui_stb_q : ser_last)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (accept) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tgt_q     <= '0;
            discard_q <= 1'b0;
            cnt_q     <= '0;
            ui_q      <= '0;
            ui_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
            ui_q      <= ui_d;
            ui_stb_q  <= ui_stb_d;
            done_q    <= done_d;
            bad_q     <= bad_d;
        end
    end

    always_comb begin
        ce_vec = '0;
        if (ser_strobe && tgt_q < TGT_INPUTS) ce_vec = 6'd1 << tgt_q;
        ce_vec[UIO_INPUTS_CE-UIO_W_CE] = ui_stb_q;
        pin_uio = '0;
        pin_uio[UIO_PARAM_LSB +: PARAM_BITS] = ser_dibit;
        pin_uio[UIO_INPUTS_CE:UIO_W_CE] = ce_vec;
    end

    assign pin_ui     = ui_q;
    assign busy       = (state_q != ST_IDLE) && !reset;
    assign frame_done = done_q;
    assign bad_target = bad_q;

endmodule

// File: tb/tb_nn_param_streamer.sv
// Bench for nn_param_streamer: directed frames plus random frames compared
// against a frame-level model of the expected strobe sequence.
module tb_nn_param_streamer;

    logic       clk = 1'b0;
    logic       reset, s_valid, hold;
    logic [7:0] s_data;
    logic       s_ready, busy, frame_done, bad_target;
    logic [7:0] pin_ui, pin_uio;

    nn_param_streamer #(.PARAM_BITS(2), .LEN_BITS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .hold      (hold),
        .pin_ui    (pin_ui),
        .pin_uio   (pin_uio),
        .busy      (busy),
        .frame_done(frame_done),
        .bad_target(bad_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        logic [2:0]  ce;
        logic [7:0]  val;
    } ev_t;

    ev_t         evq[$];
    ev_t         expq[$];
    int unsigned done_q[$];
    int unsigned bad_q[$];
    int unsigned multi_q[$];
    int unsigned cyc = 0;
    logic [7:0]  fb[$];
    int          total = 0;
    int          bad = 0;

    // Pin monitor: every strobe is logged with its cycle number
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if ($countones(pin_uio[7:2]) > 1) multi_q.push_back(cyc);
        for (int k = 0; k < 6; k++)
            if (pin_uio[2+k] === 1'b1)
                evq.push_back('{cyc, 3'(k), (k == 5) ? pin_ui : {6'd0, pin_uio[1:0]}});
        if (frame_done === 1'b1) done_q.push_back(cyc);
        if (bad_target === 1'b1) bad_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mon();
        evq.delete();
        done_q.delete();
        bad_q.delete();
        multi_q.delete();
    endtask

    // Reference model: the strobe list a frame should produce
    task automatic build_exp();
        logic [2:0] t;
        int         len;
        logic [7:0] b;
        t   = fb[0][7:5];
        len = {fb[2], fb[1]};
        expq.delete();
        if (t > 3'd5) return;
        for (int i = 0; i < len; i++) begin
            b = fb[3+i];
            if (t == 3'd5) expq.push_back('{0, t, b});
            else for (int d = 0; d < 4; d++) expq.push_back('{0, t, {6'd0, b[2*d +: 2]}});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_byte: byte %h never accepted (s_ready=%b), required acceptance within 100 cycles", b, s_ready);
        end
    endtask

    task automatic send_frame(input bit rnd);
        for (int i = 0; i < fb.size(); i++) begin
            if (rnd && i >= 3 && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                hold    = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 hold = 1'b0;
            end
            send_byte(fb[i]);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            @(negedge clk);
            idle = !busy;
        end
        @(posedge clk);
        #1;
        if (!idle) begin
            total++; bad++;
            $display("FAIL wait_idle: busy=%b after 200 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; hold = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
        total++; if (pin_uio !== 8'h00) begin bad++; $display("FAIL rst_uio: got %h want 00", pin_uio); end
        total++; if (pin_ui !== 8'h00) begin bad++; $display("FAIL rst_ui: got %h want 00", pin_ui); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if ({frame_done, bad_target} !== 2'b00) begin bad++; $display("FAIL rst_pulses: got %b want 00", {frame_done, bad_target}); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", s_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_w_frame();
        clear_mon();
        fb = '{8'h00, 8'h02, 8'h00, 8'hE4, 8'h1B};
        build_exp();
        send_frame(1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        total++; if (evq.size() !== 8) begin bad++; $display("FAIL w_count: got %0d strobes want 8", evq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i].ce !== 3'd0 || evq[i].val !== expq[i].val)
                begin bad++; $display("FAIL w_dibit[%0d]: got ce%0d/%0d want ce0/%0d", i, evq[i].ce, evq[i].val, expq[i].val); end
        end
        if (evq.size() == 8) begin
            total++; if (evq[7].cyc - evq[0].cyc !== 7) begin bad++; $display("FAIL w_gapless: span %0d want 7", evq[7].cyc - evq[0].cyc); end
            total++; if (done_q.size() !== 1 || done_q[0] !== evq[7].cyc + 1)
                begin bad++; $display("FAIL w_done: got %0d pulses first@%0d want 1@%0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : 0, evq[7].cyc + 1); end
        end
        total++; if (multi_q.size() !== 0) begin bad++; $display("FAIL w_onehot: %0d multi-ce cycles want 0", multi_q.size()); end
    endtask

    task automatic test_inputs();
        clear_mon();
        fb = '{8'hA0, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        build_exp();
        send_frame(1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        total++; if (evq.size() !== 3) begin bad++; $display("FAIL in_count: got %0d strobes want 3", evq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i].ce !== 3'd5 || evq[i].val !== expq[i].val || evq[i].cyc !== evq[0].cyc + i)
                begin bad++; $display("FAIL in_byte[%0d]: got ce%0d/%h@%0d want ce5/%h@%0d", i, evq[i].ce, evq[i].val, evq[i].cyc, expq[i].val, evq[0].cyc + i); end
        end
        total++; if (done_q.size() !== 1) begin bad++; $display("FAIL in_done: got %0d pulses want 1", done_q.size()); end
    endtask

    task automatic test_hold();
        int seen;
        clear_mon();
        fb = '{8'h40, 8'h01, 8'h00, 8'hFF};
        build_exp();
        send_frame(1'b0);
        seen = 0;
        for (int n = 0; n < 20 && seen < 2; n++) begin
            @(negedge clk);
            if (pin_uio[4] === 1'b1) seen++;
        end
        total++; if (seen !== 2) begin bad++; $display("FAIL hold_start: saw %0d strobes want 2", seen); end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) hold = 1'b0;
            @(negedge clk);
            total++; if (pin_uio !== 8'h03) begin bad++; $display("FAIL hold_pins[%0d]: got %h want 03", i, pin_uio); end
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        total++; if (evq.size() !== 4) begin bad++; $display("FAIL hold_count: got %0d strobes want 4", evq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i].ce !== 3'd2 || evq[i].val !== expq[i].val)
                begin bad++; $display("FAIL hold_dibit[%0d]: got ce%0d/%0d want ce2/%0d", i, evq[i].ce, evq[i].val, expq[i].val); end
        end
        if (evq.size() == 4) begin
            total++; if (evq[3].cyc - evq[0].cyc + 1 !== 7) begin bad++; $display("FAIL hold_duration: got %0d cycles want 7", evq[3].cyc - evq[0].cyc + 1); end
        end
        total++; if (done_q.size() !== 1) begin bad++; $display("FAIL hold_done: got %0d pulses want 1", done_q.size()); end
    endtask

    task automatic test_bad();
        clear_mon();
        fb = '{8'hE0, 8'h02, 8'h00, 8'hAA, 8'hBB};
        send_frame(1'b0);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_idle: busy=%b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bad_q.size() !== 1) begin bad++; $display("FAIL bad_pulse: got %0d pulses want 1", bad_q.size()); end
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL bad_ce: got %0d strobes want 0", evq.size()); end
        total++; if (done_q.size() !== 0) begin bad++; $display("FAIL bad_done: got %0d pulses want 0", done_q.size()); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        fb = '{8'h20, 8'h00, 8'h00};
        send_frame(1'b0);
        @(negedge clk);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", frame_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (evq.size() !== 0) begin bad++; $display("FAIL zero_ce: got %0d strobes want 0", evq.size()); end
        clear_mon();
        fb = '{8'h60, 8'h01, 8'h00, 8'h05};
        build_exp();
        send_frame(1'b0);
        wait_idle();
        total++; if (evq.size() !== 4) begin bad++; $display("FAIL bnf_count: got %0d strobes want 4", evq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i].ce !== 3'd3 || evq[i].val !== expq[i].val)
                begin bad++; $display("FAIL bnf_dibit[%0d]: got ce%0d/%0d want ce3/%0d", i, evq[i].ce, evq[i].val, expq[i].val); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_mon();
        fb = '{8'h00, 8'h01, 8'h00, 8'h9C};
        send_frame(1'b0);
        seen = 0;
        for (int n = 0; n < 20 && seen < 2; n++) begin
            @(negedge clk);
            if (pin_uio[2] === 1'b1) seen++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (pin_uio !== 8'h00) begin bad++; $display("FAIL rmid_uio: got %h want 00", pin_uio); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", s_ready); end
        @(posedge clk);
        #1;
        clear_mon();
        fb = '{8'h80, 8'h01, 8'h00, 8'h0F};
        build_exp();
        send_frame(1'b0);
        wait_idle();
        total++; if (evq.size() !== 4) begin bad++; $display("FAIL rmid_count: got %0d strobes want 4", evq.size()); end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            total++;
            if (evq[i].ce !== 3'd4 || evq[i].val !== expq[i].val)
                begin bad++; $display("FAIL rmid_dibit[%0d]: got ce%0d/%0d want ce4/%0d", i, evq[i].ce, evq[i].val, expq[i].val); end
        end
        total++; if (done_q.size() !== 1) begin bad++; $display("FAIL rmid_done: got %0d pulses want 1", done_q.size()); end
    endtask

    task automatic test_random();
        logic [2:0] t;
        int         len, exp_done;
        for (int f = 0; f < 24; f++) begin
            t   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 5);
            fb.delete();
            fb.push_back({t, 5'($urandom)});
            fb.push_back(len[7:0]);
            fb.push_back(8'h00);
            for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
            clear_mon();
            build_exp();
            send_frame(1'b1);
            wait_idle();
            repeat (2) @(posedge clk);
            #1;
            exp_done = (t <= 3'd5) ? 1 : 0;
            total++; if (evq.size() !== expq.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d strobes want %0d", f, evq.size(), expq.size()); end
            for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
                total++;
                if (evq[i].ce !== expq[i].ce || evq[i].val !== expq[i].val)
                    begin bad++; $display("FAIL rnd%0d_ev[%0d]: got ce%0d/%h want ce%0d/%h", f, i, evq[i].ce, evq[i].val, expq[i].ce, expq[i].val); end
            end
            total++; if (done_q.size() !== exp_done) begin bad++; $display("FAIL rnd%0d_done: got %0d want %0d", f, done_q.size(), exp_done); end
            total++; if (bad_q.size() !== 1 - exp_done) begin bad++; $display("FAIL rnd%0d_bad: got %0d want %0d", f, bad_q.size(), 1 - exp_done); end
            total++; if (multi_q.size() !== 0) begin bad++; $display("FAIL rnd%0d_onehot: %0d multi-ce cycles want 0", f, multi_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_w_frame();
        test_inputs();
        test_hold();
        test_bad();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
